// File: rtl/melody_sequencer.sv
// Melody sequencer: steps through a loadable note memory and drives the one-hot
// pitch word, octave band and band-load strobe of the musicbox tone generator.
module melody_sequencer #(
    parameter int DEPTH          = 64,
    parameter int AW             = 6,
    parameter int TICKS_PER_BEAT = 12500000,
    parameter int GAP_TICKS      = 500000,
    parameter int CW             = 32
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic          stop,
    input  logic          pause,
    input  logic          loop,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_addr,
    input  logic [15:0]   wr_data,
    output logic [15:0]   sw,
    output logic [2:0]    band,
    output logic          adj,
    output logic          busy,
    output logic          done,
    output logic [AW-1:0] cur_addr
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_DECODE,
        S_NOTE,
        S_GAP,
        S_ADVANCE
    } state_t;

    localparam logic [CW-1:0] TPB_LAST  = CW'(TICKS_PER_BEAT - 1);
    localparam logic [CW-1:0] GAP_LAST  = CW'((GAP_TICKS > 0) ? (GAP_TICKS - 1) : 0);
    localparam logic [AW-1:0] ADDR_LAST = AW'(DEPTH - 1);

    state_t          state_q, state_d;
    logic [AW-1:0]   cur_addr_q, cur_addr_d;
    logic [15:0]     sw_q, sw_d;
    logic [2:0]      band_q, band_d;
    logic            done_q, done_d;
    logic [CW-1:0]   tick_q, tick_d;
    logic [CW-1:0]   beat_q, beat_d;
    logic [CW-1:0]   dur_last_q, dur_last_d;
    logic            adj_c;

    logic [15:0]     mem_q [DEPTH];
    logic [15:0]     rd_q;

    logic            ent_end;
    logic            ent_rest;
    logic [2:0]      ent_band;
    logic [3:0]      ent_pitch;
    logic [6:0]      ent_dur;

    assign ent_end   = rd_q[15];
    assign ent_rest  = rd_q[14];
    assign ent_band  = rd_q[13:11];
    assign ent_pitch = rd_q[10:7];
    assign ent_dur   = rd_q[6:0];

    // Memory is not reset; the read port follows cur_addr so the entry is ready one cycle after FETCH.
    always_ff @(posedge clk) begin
        if (wr_en && (state_q == S_IDLE)) begin
            mem_q[wr_addr] <= wr_data;
        end
        rd_q <= mem_q[cur_addr_q];
    end

    always_comb begin
        state_d    = state_q;
        cur_addr_d = cur_addr_q;
        sw_d       = sw_q;
        band_d     = band_q;
        done_d     = 1'b0;
        tick_d     = tick_q;
        beat_d     = beat_q;
        dur_last_d = dur_last_q;
        adj_c      = 1'b0;

        if (stop) begin
            state_d = S_IDLE;
            sw_d    = '0;
        end else if (state_q == S_IDLE) begin
            if (start) begin
                cur_addr_d = '0;
                state_d    = S_FETCH;
            end
        end else if (!pause) begin
            case (state_q)
                S_FETCH: begin
                    state_d = S_DECODE;
                end
                S_DECODE: begin
                    if (ent_end) begin
                        if (loop) begin
                            cur_addr_d = '0;
                            state_d    = S_FETCH;
                        end else begin
                            done_d  = 1'b1;
                            state_d = S_IDLE;
                        end
                    end else begin
                        band_d     = ent_band;
                        adj_c      = 1'b1;
                        sw_d       = ent_rest ? 16'h0000 : (16'(1) << ent_pitch);
                        tick_d     = '0;
                        beat_d     = '0;
                        dur_last_d = (ent_dur == 7'd0) ? '0 : CW'(ent_dur - 7'd1);
                        state_d    = S_NOTE;
                    end
                end
                S_NOTE: begin
                    if (tick_q == TPB_LAST) begin
                        tick_d = '0;
                        if (beat_q == dur_last_q) begin
                            beat_d  = '0;
                            sw_d    = '0;
                            state_d = (GAP_TICKS == 0) ? S_ADVANCE : S_GAP;
                        end else begin
                            beat_d = beat_q + 1'b1;
                        end
                    end else begin
                        tick_d = tick_q + 1'b1;
                    end
                end
                S_GAP: begin
                    if (tick_q == GAP_LAST) begin
                        tick_d  = '0;
                        state_d = S_ADVANCE;
                    end else begin
                        tick_d = tick_q + 1'b1;
                    end
                end
                S_ADVANCE: begin
                    // Running off the end of memory counts as an END entry.
                    if (cur_addr_q == ADDR_LAST) begin
                        cur_addr_d = '0;
                        if (loop) begin
                            state_d = S_FETCH;
                        end else begin
                            done_d  = 1'b1;
                            state_d = S_IDLE;
                        end
                    end else begin
                        cur_addr_d = cur_addr_q + 1'b1;
                        state_d    = S_FETCH;
                    end
                end
                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            cur_addr_q <= '0;
            sw_q       <= '0;
            band_q     <= 3'h2;
            done_q     <= 1'b0;
            tick_q     <= '0;
            beat_q     <= '0;
            dur_last_q <= '0;
        end else begin
            state_q    <= state_d;
            cur_addr_q <= cur_addr_d;
            sw_q       <= sw_d;
            band_q     <= band_d;
            done_q     <= done_d;
            tick_q     <= tick_d;
            beat_q     <= beat_d;
            dur_last_q <= dur_last_d;
        end
    end

    // The new band is presented alongside the adj strobe so the tone generator can latch it.
    assign adj      = adj_c && !rst;
    assign band     = adj ? ent_band : band_q;
    assign sw       = pause ? 16'h0000 : sw_q;
    assign busy     = (state_q != S_IDLE);
    assign done     = done_q;
    assign cur_addr = cur_addr_q;

endmodule

// File: tb/tb_melody_sequencer.sv
// Directed bench for melody_sequencer with a short beat (4 ticks) and gap (2 ticks).
module tb_melody_sequencer;

    localparam int DEPTH = 8;
    localparam int AW    = 3;
    localparam int TPB   = 4;
    localparam int GAP   = 2;
    localparam int CW    = 32;

    logic          clk = 1'b0;
    logic          rst, start, stop, pause, loop, wr_en;
    logic [AW-1:0] wr_addr;
    logic [15:0]   wr_data;
    logic [15:0]   sw;
    logic [2:0]    band;
    logic          adj, busy, done;
    logic [AW-1:0] cur_addr;

    melody_sequencer #(
        .DEPTH(DEPTH), .AW(AW), .TICKS_PER_BEAT(TPB), .GAP_TICKS(GAP), .CW(CW)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .stop(stop), .pause(pause), .loop(loop),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .sw(sw), .band(band), .adj(adj), .busy(busy), .done(done), .cur_addr(cur_addr)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // per-run observations
    int          n_busy, n_hi, n_adj, n_done, adj_band, first_hi, end_c;
    int          pause_leak, onehot_err, adj_consec, n_addr;
    int          end_sw, end_done;
    logic [15:0] last_sw;
    int          addr_seq [16];

    typedef struct {
        logic [15:0] entry;
        logic [15:0] exp_sw;
        int          exp_band;
        int          exp_hi;
        int          exp_busy;
    } vec_t;

    vec_t vecs [5];

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic mem_write(input int a, input logic [15:0] d);
        @(negedge clk);
        wr_en   = 1'b1;
        wr_addr = AW'(a);
        wr_data = d;
        @(negedge clk);
        wr_en   = 1'b0;
    endtask

    // Pulse start (optionally writing entry 0 in the same cycle).
    task automatic kick(input logic do_wr, input logic [15:0] d);
        @(negedge clk);
        start   = 1'b1;
        wr_en   = do_wr;
        wr_addr = '0;
        wr_data = d;
    endtask

    // Cycle c=0 is the first cycle after the start edge.
    task automatic run(input int maxc, input int pf, input int pl, input int stop_at,
                       input int wr_at, input int st_at);
        logic prev_adj;
        logic [AW-1:0] prev_addr;
        n_busy = 0; n_hi = 0; n_adj = 0; n_done = 0; adj_band = -1; first_hi = -1;
        end_c = -1; pause_leak = 0; onehot_err = 0; adj_consec = 0; n_addr = 0;
        end_sw = -1; end_done = -1; last_sw = '0; prev_adj = 1'b0; prev_addr = '0;
        for (int c = 0; c < maxc; c++) begin
            @(negedge clk);
            start   = (c == st_at);
            stop    = (c == stop_at);
            pause   = (c >= pf) && (c < pf + pl);
            wr_en   = (c == wr_at);
            wr_addr = '0;
            wr_data = 16'h0001;
            #1;
            if (busy) n_busy++;
            if (sw != 16'h0000) begin
                n_hi++;
                last_sw = sw;
                if (first_hi < 0) first_hi = c;
            end
            if ((sw & (sw - 16'h0001)) != 16'h0000) onehot_err++;
            if (pause && sw != 16'h0000) pause_leak++;
            if (adj) begin
                n_adj++;
                if (adj_band < 0) adj_band = int'(band);
            end
            if (adj && prev_adj) adj_consec++;
            prev_adj = adj;
            if (done) n_done++;
            if (busy && (n_addr == 0 || cur_addr != prev_addr) && n_addr < 16) begin
                addr_seq[n_addr] = int'(cur_addr);
                n_addr++;
            end
            prev_addr = cur_addr;
            if (end_c < 0 && !busy) begin
                end_c    = c;
                end_sw   = int'(sw);
                end_done = int'(done);
            end
            if (end_c >= 0 && c >= end_c + 2) break;
        end
        start = 1'b0; stop = 1'b0; pause = 1'b0; wr_en = 1'b0;
        checks++;
        if (end_c < 0) begin
            errors++;
            $display("FAIL run_timeout: got no idle within %0d cycles expected idle", maxc);
        end
    endtask

    initial begin
        vecs[0] = '{16'h1C83, 16'h0200, 3, 12, 19};  // pitch 9, band 3, dur 3
        vecs[1] = '{16'h2801, 16'h0001, 5,  4, 11};  // pitch 0, band 5, dur 1
        vecs[2] = '{16'h0780, 16'h8000, 0,  4, 11};  // pitch 15, band 0, dur 0
        vecs[3] = '{16'h7A02, 16'h0000, 7,  0, 15};  // REST, band 7, dur 2
        vecs[4] = '{16'h0B85, 16'h0080, 1, 20, 27};  // pitch 7, band 1, dur 5

        rst = 1'b1; start = 1'b0; stop = 1'b0; pause = 1'b0; loop = 1'b0;
        wr_en = 1'b0; wr_addr = '0; wr_data = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        #1;
        chk("reset_sw", int'(sw), 0);
        chk("reset_band", int'(band), 2);
        chk("reset_adj", int'(adj), 0);
        chk("reset_busy", int'(busy), 0);
        chk("reset_done", int'(done), 0);
        chk("reset_addr", int'(cur_addr), 0);

        // Single-note table; entry 0 is written in the start cycle itself.
        for (int i = 0; i < 5; i++) begin
            mem_write(1, 16'h8000);
            kick(1'b1, vecs[i].entry);
            run(100, -1, 0, -1, -1, -1);
            chk($sformatf("v%0d_busy", i), n_busy, vecs[i].exp_busy);
            chk($sformatf("v%0d_hi", i), n_hi, vecs[i].exp_hi);
            chk($sformatf("v%0d_sw", i), int'(last_sw), int'(vecs[i].exp_sw));
            chk($sformatf("v%0d_adj", i), n_adj, 1);
            chk($sformatf("v%0d_band", i), adj_band, vecs[i].exp_band);
            chk($sformatf("v%0d_done", i), n_done, 1);
            chk($sformatf("v%0d_done_at_idle", i), end_done, 1);
            chk($sformatf("v%0d_onehot", i), onehot_err, 0);
        end

        // REST dur 2 then pitch 0 dur 1.
        mem_write(0, 16'h4002);
        mem_write(1, 16'h0001);
        mem_write(2, 16'h8000);
        kick(1'b0, 16'h0000);
        run(100, -1, 0, -1, -1, -1);
        chk("rest_first_hi", first_hi, 15);
        chk("rest_hi", n_hi, 4);
        chk("rest_sw", int'(last_sw), 1);
        chk("rest_busy", n_busy, 24);
        chk("rest_adj", n_adj, 2);

        // Pause for 5 cycles in the middle of a note.
        mem_write(0, 16'h1C83);
        mem_write(1, 16'h8000);
        kick(1'b0, 16'h0000);
        run(100, 5, 5, -1, -1, -1);
        chk("pause_leak", pause_leak, 0);
        chk("pause_hi", n_hi, 12);
        chk("pause_busy", n_busy, 24);
        chk("pause_adj", n_adj, 1);
        chk("pause_done", n_done, 1);

        // Write and start while busy are both ignored; replay shows the original entry.
        kick(1'b0, 16'h0000);
        run(100, -1, 0, -1, 3, 4);
        chk("busywr_busy", n_busy, 19);
        kick(1'b0, 16'h0000);
        run(100, -1, 0, -1, -1, -1);
        chk("replay_sw", int'(last_sw), 16'h0200);
        chk("replay_hi", n_hi, 12);

        // Looping two-note melody, stopped in the GAP of the third note.
        mem_write(0, 16'h1081);
        mem_write(1, 16'h1101);
        mem_write(2, 16'h8000);
        loop = 1'b1;
        kick(1'b0, 16'h0000);
        run(100, -1, 0, 26, -1, -1);
        loop = 1'b0;
        chk("loop_naddr", n_addr, 4);
        chk("loop_addr1", addr_seq[1], 1);
        chk("loop_addr2", addr_seq[2], 2);
        chk("loop_addr3", addr_seq[3], 0);
        chk("loop_adj", n_adj, 3);
        chk("loop_adj_consec", adj_consec, 0);
        chk("loop_done", n_done, 0);
        chk("stop_idle_at", end_c, 27);
        chk("stop_sw", end_sw, 0);

        // Memory full of notes, no END: wrap ends the melody.
        for (int a = 0; a < DEPTH; a++) mem_write(a, 16'((a << 7) | 1));
        kick(1'b0, 16'h0000);
        run(200, -1, 0, -1, -1, -1);
        chk("full_busy", n_busy, 72);
        chk("full_adj", n_adj, 8);
        chk("full_hi", n_hi, 32);
        chk("full_naddr", n_addr, 8);
        chk("full_done", n_done, 1);
        chk("full_onehot", onehot_err, 0);

        // Reset in the middle of a note.
        mem_write(0, 16'h1C83);
        mem_write(1, 16'h8000);
        kick(1'b0, 16'h0000);
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        chk("pre_rst_busy", int'(busy), 1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("rst_busy", int'(busy), 0);
        chk("rst_sw", int'(sw), 0);
        chk("rst_band", int'(band), 2);
        chk("rst_addr", int'(cur_addr), 0);
        chk("rst_done", int'(done), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
